// File: rtl/ticket_pkg.sv
// Shared definitions for the bill acceptor and the ticket machine it feeds.
// Holds the controller state encoding, the sensor denomination codes and the counter widths.
// Also provides a helper that says which sensor codes can be credited.
package ticket_pkg;

  // Controller states; the ticket machine decodes these too, so keep the order stable.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SETTLE       = 3'd1,
    CREDIT       = 3'd2,
    EJECT        = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  // Sensor denomination codes; 2'b00 and 2'b11 are not supported.
  localparam logic [1:0] CODE_TEN    = 2'b01;
  localparam logic [1:0] CODE_TWENTY = 2'b10;

  // Settle/eject counters span 1..15.
  localparam int TMR_W = 4;

  // Credited-bill counter width and saturation value.
  localparam int         CNT_W   = 8;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic code_supported(input logic [1:0] code);
    return (code == CODE_TEN) || (code == CODE_TWENTY);
  endfunction

endpackage

// File: rtl/bill_acceptor_if.sv
// Bundle between the bill sensor / ticket machine side and the bill acceptor.
// master: sensor + ticket machine side (drives bill_present, bill_code, ready, bill).
// slave : bill acceptor (drives ten, twenty, eject, busy, accepted_cnt).
interface bill_acceptor_if;
  import ticket_pkg::*;

  logic             bill_present;
  logic [1:0]       bill_code;
  logic             ready;
  logic             bill;
  logic             ten;
  logic             twenty;
  logic             eject;
  logic             busy;
  logic [CNT_W-1:0] accepted_cnt;

  modport master (
    output bill_present, bill_code, ready, bill,
    input  ten, twenty, eject, busy, accepted_cnt
  );

  modport slave (
    input  bill_present, bill_code, ready, bill,
    output ten, twenty, eject, busy, accepted_cnt
  );

endinterface

// File: rtl/bill_settle_timer.sv
// Settle timer: counts consecutive stable samples of a bill code.
// Latency: o_done is a compare on the registered count, valid the cycle after load/inc.
// Ports: clk, clear_n (sync active-low), i_load (count := 1), i_inc (count += 1), o_done (count == SETTLE_CYCLES).
module bill_settle_timer
  import ticket_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic i_load,
  input  logic i_inc,
  output logic o_done
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= TMR_W'(1);
    end else if (i_inc && (r_count != {TMR_W{1'b1}})) begin
      // Holding at all-ones keeps a stray increment from wrapping back into range.
      r_count <= r_count + TMR_W'(1);
    end
  end

  assign o_done = (r_count == TMR_W'(SETTLE_CYCLES));

endmodule

// File: rtl/bill_acceptor.sv
// Bill acceptor: debounces the sensor code, then credits ($10/$20 pulse) or ejects the bill.
// Latency: credit pulse appears the cycle after the (SETTLE_CYCLES+1)-th stable sample; all outputs registered.
// Backpressure: ready|bill is sampled once, in the judging cycle; if low the bill is ejected.
// Ports: clk, clear_n (sync active-low); bus (slave): bill_present, bill_code, ready, bill in;
//        ten, twenty (credit pulses), eject (return motor), busy, accepted_cnt (saturating) out.
module bill_acceptor
  import ticket_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int EJECT_CYCLES  = 3
) (
  input logic            clk,
  input logic            clear_n,
  bill_acceptor_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_code;
  logic [1:0]       w_code_next;
  logic [TMR_W-1:0] r_eject_cnt;
  logic [TMR_W-1:0] w_eject_cnt_next;
  logic             w_tmr_load;
  logic             w_tmr_inc;
  logic             w_tmr_done;

  logic             r_ten;
  logic             r_twenty;
  logic             r_eject;
  logic             r_busy;
  logic [CNT_W-1:0] r_accepted;

  bill_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .clear_n (clear_n),
    .i_load  (w_tmr_load),
    .i_inc   (w_tmr_inc),
    .o_done  (w_tmr_done)
  );

  always_comb begin
    w_state_next     = r_state;
    w_code_next      = r_code;
    w_eject_cnt_next = r_eject_cnt;
    w_tmr_load       = 1'b0;
    w_tmr_inc        = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.bill_present) begin
          w_code_next  = bus.bill_code;
          w_tmr_load   = 1'b1;
          w_state_next = SETTLE;
        end
      end

      SETTLE: begin
        // Priority: removal beats a code change, which beats the judgement.
        if (!bus.bill_present) begin
          w_state_next = IDLE;
        end else if (bus.bill_code != r_code) begin
          w_code_next = bus.bill_code;
          w_tmr_load  = 1'b1;
        end else if (w_tmr_done) begin
          if (code_supported(r_code) && (bus.ready || bus.bill)) begin
            w_state_next = CREDIT;
          end else begin
            w_state_next     = EJECT;
            w_eject_cnt_next = TMR_W'(1);
          end
        end else begin
          w_tmr_inc = 1'b1;
        end
      end

      CREDIT: begin
        w_state_next = WAIT_RELEASE;
      end

      EJECT: begin
        // Strobe length is fixed once started; the sensor is ignored here.
        if (r_eject_cnt == TMR_W'(EJECT_CYCLES)) begin
          w_state_next = WAIT_RELEASE;
        end else begin
          w_eject_cnt_next = r_eject_cnt + TMR_W'(1);
        end
      end

      WAIT_RELEASE: begin
        // One insertion, one decision: wait for the throat to clear.
        if (!bus.bill_present) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered decodes of the state being entered, so they line up
  // with the state register and never see an input combinationally.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state     <= IDLE;
      r_code      <= '0;
      r_eject_cnt <= '0;
      r_ten       <= 1'b0;
      r_twenty    <= 1'b0;
      r_eject     <= 1'b0;
      r_busy      <= 1'b0;
      r_accepted  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_code      <= w_code_next;
      r_eject_cnt <= w_eject_cnt_next;
      r_ten       <= (w_state_next == CREDIT) && (w_code_next == CODE_TEN);
      r_twenty    <= (w_state_next == CREDIT) && (w_code_next == CODE_TWENTY);
      r_eject     <= (w_state_next == EJECT);
      r_busy      <= (w_state_next != IDLE);
      if ((w_state_next == CREDIT) && (r_accepted != CNT_MAX)) begin
        r_accepted <= r_accepted + CNT_W'(1);
      end
    end
  end

  assign bus.ten          = r_ten;
  assign bus.twenty       = r_twenty;
  assign bus.eject        = r_eject;
  assign bus.busy         = r_busy;
  assign bus.accepted_cnt = r_accepted;

endmodule
